ws2812_strip_driver: RTL and testbench

- Frame-loop consumer of the screen bus: sweeps led_number 0..MAX_POS-1, captures the G/R/B intensities returned by the active screen pipeline, and serialises them onto the single-wire WS2812 data line.
- Sits between the screen manager output and the LED-strip pin.
- Screens are combinational in led_number; this block owns all timing.

---
 rtl/ws2812_pkg.sv | 29 ++
 rtl/ws2812_strip_driver_if.sv | 29 ++
 rtl/ws2812_bit_encoder.sv | 71 +++++++
 rtl/ws2812_strip_driver.sv | 127 ++++++++++++
 tb/tb_ws2812_strip_driver.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Package : ws2812_pkg
// Desc    : Shared state encoding, default timing and word packing for the
//           WS2812 strip driver.
// Rev     : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

   localparam int c_DEF_MAX_POS   = 109;
   localparam int c_DEF_T0H_CYC   = 20;
   localparam int c_DEF_T1H_CYC   = 40;
   localparam int c_DEF_BIT_CYC   = 63;
   localparam int c_DEF_RESET_CYC = 15000;
   localparam int c_WORD_W        = 24;

   typedef enum logic [1:0] {
      ST_RESET_LOW = 2'd0,
      ST_FETCH     = 2'd1,
      ST_LATCH     = 2'd2,
      ST_SEND      = 2'd3
   } state_t;

   function automatic logic [7:0] clamp8(input logic [7:0] value, input logic [7:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_strip_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : ws2812_strip_driver_if
// Desc      : Screen bus - LED index out to the screens, GRB intensities back.
// Rev       : 1.0 - initial release
// ============================================================================
interface ws2812_strip_driver_if #(
   parameter int LED_W = 7
);
   logic [LED_W-1:0] led_number;
   logic [7:0]       i_red_intensity;
   logic [7:0]       i_green_intensity;
   logic [7:0]       i_blue_intensity;

   modport master (
      output led_number,
      input  i_red_intensity,
      input  i_green_intensity,
      input  i_blue_intensity
   );

   modport slave (
      input  led_number,
      output i_red_intensity,
      output i_green_intensity,
      output i_blue_intensity
   );
endinterface
`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module : ws2812_bit_encoder
// Desc   : Serialises one 24-bit GRB word MSB first using WS2812 pulse widths.
// Rev    : 1.0 - initial release
// ============================================================================
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int T0H_CYC = c_DEF_T0H_CYC,
   parameter int T1H_CYC = c_DEF_T1H_CYC,
   parameter int BIT_CYC = c_DEF_BIT_CYC
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                start,
   input  wire logic [c_WORD_W-1:0] word,
   output logic                     data_out,
   output logic                     done
);

   localparam int c_CYC_W = $clog2(BIT_CYC);
   localparam int c_BIT_W = $clog2(c_WORD_W + 1);

   localparam logic [c_CYC_W-1:0] c_T0H      = c_CYC_W'(T0H_CYC);
   localparam logic [c_CYC_W-1:0] c_T1H      = c_CYC_W'(T1H_CYC);
   localparam logic [c_CYC_W-1:0] c_BIT_END  = c_CYC_W'(BIT_CYC - 1);
   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_WORD_W - 1);

   logic [c_WORD_W-1:0] r_shift_reg;
   logic [c_CYC_W-1:0]  r_cyc_cnt;
   logic [c_BIT_W-1:0]  r_bit_cnt;
   logic                r_active;

   logic w_bit_end;
   logic w_last_bit;

   assign w_bit_end  = r_active && (r_cyc_cnt == c_BIT_END);
   assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift_reg <= '0;
         r_cyc_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_active    <= 1'b0;
      end else if (start) begin
         r_shift_reg <= word;
         r_cyc_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_active    <= 1'b1;
      end else if (r_active) begin
         if (w_bit_end) begin
            r_cyc_cnt   <= '0;
            r_shift_reg <= {r_shift_reg[c_WORD_W-2:0], 1'b0};
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            if (w_last_bit) begin
               r_active <= 1'b0;
            end
         end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
         end
      end
   end

   // High phase length is picked by the bit currently at the MSB.
   assign data_out = r_active && (r_cyc_cnt < (r_shift_reg[c_WORD_W-1] ? c_T1H : c_T0H));
   assign done     = w_bit_end && w_last_bit;

endmodule
`default_nettype wire

// File: rtl/ws2812_strip_driver.sv
`default_nettype none
// ============================================================================
// Module : ws2812_strip_driver
// Desc   : Frame loop over the strip: fetches each LED's GRB value from the
//          screen bus and drives the WS2812 line, with a reset gap per frame.
// Macro  : WS2812_INTENSITY_CLAMP_EN - clamp each channel to MAX_INTENSITY.
// Rev    : 1.0 - initial release
// ============================================================================
module ws2812_strip_driver
   import ws2812_pkg::*;
#(
   parameter int MAX_POS   = c_DEF_MAX_POS,
   parameter int T0H_CYC   = c_DEF_T0H_CYC,
   parameter int T1H_CYC   = c_DEF_T1H_CYC,
   parameter int BIT_CYC   = c_DEF_BIT_CYC,
   parameter int RESET_CYC = c_DEF_RESET_CYC
`ifdef WS2812_INTENSITY_CLAMP_EN
   ,
   parameter int MAX_INTENSITY = 32
`endif
) (
   input  wire logic             clk,
   input  wire logic             rst,
   ws2812_strip_driver_if.master scr,
   output logic                  data_out,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int c_LED_W = $clog2(MAX_POS);
   localparam int c_RST_W = $clog2(RESET_CYC);

   localparam logic [c_LED_W-1:0] c_LAST_LED = c_LED_W'(MAX_POS - 1);
   localparam logic [c_RST_W-1:0] c_RST_END  = c_RST_W'(RESET_CYC - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_LED_W-1:0]   r_led_number;
   logic [c_LED_W-1:0]   w_led_nxt;
   logic [c_RST_W-1:0]   r_gap_cnt;
   logic [c_RST_W-1:0]   w_gap_nxt;
   logic                 r_frame_done;
   logic                 w_frame_done_nxt;
   logic                 w_start;
   logic                 w_enc_done;
   logic [c_WORD_W-1:0]  w_word;

`ifdef WS2812_INTENSITY_CLAMP_EN
   localparam logic [7:0] c_MAX_INT = 8'(MAX_INTENSITY);

   assign w_word = {clamp8(scr.i_green_intensity, c_MAX_INT),
                    clamp8(scr.i_red_intensity,   c_MAX_INT),
                    clamp8(scr.i_blue_intensity,  c_MAX_INT)};
`else
   assign w_word = {scr.i_green_intensity, scr.i_red_intensity, scr.i_blue_intensity};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_RESET_LOW;
         r_led_number <= '0;
         r_gap_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_led_number <= w_led_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_led_nxt        = r_led_number;
      w_gap_nxt        = '0;
      w_frame_done_nxt = 1'b0;
      w_start          = 1'b0;
      unique case (r_state)
         ST_RESET_LOW: begin
            if (r_gap_cnt == c_RST_END) begin
               w_state_nxt = ST_FETCH;
               w_led_nxt   = '0;
            end else begin
               w_gap_nxt = r_gap_cnt + 1'b1;
            end
         end
         // One idle cycle lets the screens settle on the new led_number.
         ST_FETCH: w_state_nxt = ST_LATCH;
         ST_LATCH: begin
            w_start     = 1'b1;
            w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (w_enc_done) begin
               if (r_led_number == c_LAST_LED) begin
                  w_led_nxt        = '0;
                  w_frame_done_nxt = 1'b1;
                  w_state_nxt      = ST_RESET_LOW;
               end else begin
                  w_led_nxt   = r_led_number + 1'b1;
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         default: w_state_nxt = ST_RESET_LOW;
      endcase
   end

   ws2812_bit_encoder #(
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .BIT_CYC (BIT_CYC)
   ) u_bit_encoder (
      .clk      (clk),
      .rst      (rst),
      .start    (w_start),
      .word     (w_word),
      .data_out (data_out),
      .done     (w_enc_done)
   );

   assign scr.led_number = r_led_number;
   assign frame_done     = r_frame_done;
   assign busy           = (r_state != ST_RESET_LOW);

endmodule
`default_nettype wire

// File: tb/tb_ws2812_strip_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_ws2812_strip_driver
// Desc   : Scoreboard bench: decodes the serial line into GRB words and checks
//          them, plus gap, bit-period and frame timing, against expectations.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ws2812_strip_driver;

   localparam int NP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic data_out;
   logic frame_done;
   logic busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [23:0] word;
      logic [1:0]  led;
   } exp_t;

   exp_t        sb[$];
   logic [23:0] cur[NP];
   logic [23:0] vin[5][NP];
   logic [23:0] exp_plain[5][NP];
   logic [23:0] exp_clamp[5][NP];

   always #5 clk = ~clk;

   ws2812_strip_driver_if #(.LED_W(2)) scr ();

   ws2812_strip_driver #(
      .MAX_POS   (3),
      .T0H_CYC   (2),
      .T1H_CYC   (4),
      .BIT_CYC   (6),
      .RESET_CYC (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .scr        (scr),
      .data_out   (data_out),
      .frame_done (frame_done),
      .busy       (busy)
   );

   // Combinational screen model.
   always_comb begin
      scr.i_green_intensity = 8'h00;
      scr.i_red_intensity   = 8'h00;
      scr.i_blue_intensity  = 8'h00;
      if (scr.led_number < 2'd3) begin
         {scr.i_green_intensity, scr.i_red_intensity, scr.i_blue_intensity} = cur[scr.led_number];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic set_frame(input int f);
      for (int i = 0; i < NP; i++) cur[i] = vin[f][i];
   endtask

   task automatic push_frame(input int f, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
`ifdef WS2812_INTENSITY_CLAMP_EN
         e.word = exp_clamp[f][i];
`else
         e.word = exp_plain[f][i];
`endif
         e.led = 2'(i);
         sb.push_back(e);
      end
   endtask

   task automatic wait_frame(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 2000);
      chk(nm, {31'd0, frame_done}, 32'd1);
   endtask

   // Monitor: decode pulses into bits/words and check against the scoreboard.
   int          hi_len, nbits, words, gap_cnt, rise_gap;
   bit          gap_pend, prev;
   logic [23:0] shreg;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hi_len = 0; nbits = 0; words = 0; gap_cnt = 0; rise_gap = 0;
         gap_pend = 1'b1; prev = 1'b0; shreg = '0;
      end else begin
         if (frame_done) begin
            chk("frame_words", words, 32'd3);
            chk("frame_led", {30'd0, scr.led_number}, 32'd0);
            chk("frame_busy", {31'd0, busy}, 32'd0);
            words = 0; gap_cnt = 0; gap_pend = 1'b1;
         end
         if (data_out && !prev) begin
            if (gap_pend) begin
               chk("gap_len", gap_cnt, 32'd12);
               gap_pend = 1'b0;
            end
            if (nbits > 0) chk("bit_period", rise_gap, 32'd6);
            rise_gap = 0;
         end
         if (data_out) begin
            hi_len++;
         end else if (prev) begin
            chk("bit_high_len_valid", {31'd0, (hi_len == 2 || hi_len == 4)}, 32'd1);
            shreg = {shreg[22:0], (hi_len == 4)};
            nbits++;
            if (nbits == 24) begin
               if (sb.size() == 0) begin
                  chk("word_unexpected", {8'd0, shreg}, 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk("led_word", {8'd0, shreg}, {8'd0, e.word});
                  chk("led_idx", {30'd0, scr.led_number}, {30'd0, e.led});
                  chk("word_busy", {31'd0, busy}, 32'd1);
               end
               nbits = 0;
               words++;
            end
            hi_len = 0;
         end
         prev = data_out;
         gap_cnt++;
         rise_gap++;
      end
   end

   initial begin
      int n;
      int rises;
      bit p;
      // Frame vectors: input {G,R,B}, expected word plain, expected with clamp to 0x20.
      vin[0][0] = 24'h800100; exp_plain[0][0] = 24'h800100; exp_clamp[0][0] = 24'h200100;
      vin[0][1] = 24'h123456; exp_plain[0][1] = 24'h123456; exp_clamp[0][1] = 24'h122020;
      vin[0][2] = 24'hA55AC3; exp_plain[0][2] = 24'hA55AC3; exp_clamp[0][2] = 24'h202020;
      for (int i = 0; i < NP; i++) begin
         vin[1][i] = 24'h000000; exp_plain[1][i] = 24'h000000; exp_clamp[1][i] = 24'h000000;
         vin[2][i] = 24'hFFFFFF; exp_plain[2][i] = 24'hFFFFFF; exp_clamp[2][i] = 24'h202020;
         vin[4][i] = 24'h10C821; exp_plain[4][i] = 24'h10C821; exp_clamp[4][i] = 24'h102020;
      end
      vin[3][0] = 24'h0FF033; exp_plain[3][0] = 24'h0FF033; exp_clamp[3][0] = 24'h0F2020;
      vin[3][1] = 24'h010203; exp_plain[3][1] = 24'h010203; exp_clamp[3][1] = 24'h010203;
      vin[3][2] = 24'h010203; exp_plain[3][2] = 24'h010203; exp_clamp[3][2] = 24'h010203;

      rst = 1'b1;
      set_frame(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_out",   {31'd0, data_out},   32'd0);
      chk("rst_led_number", {30'd0, scr.led_number}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);

      push_frame(0, NP);
      rst = 1'b0;
      wait_frame("frame0_done");

      set_frame(1); push_frame(1, NP); wait_frame("frame_zero_done");
      set_frame(2); push_frame(2, NP); wait_frame("frame_ones_done");

      // Abort in the high phase of LED1 bit 5.
      set_frame(3); push_frame(3, 1);
      n = 0;
      while (scr.led_number != 2'd1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_led1", {30'd0, scr.led_number}, 32'd1);
      rises = 0; p = data_out; n = 0;
      while (rises < 6 && n < 200) begin
         @(negedge clk);
         if (data_out && !p) rises++;
         p = data_out;
         n++;
      end
      chk("reach_bit5", rises, 32'd6);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_data_out", {31'd0, data_out}, 32'd0);
      chk("abort_led",      {30'd0, scr.led_number}, 32'd0);
      chk("abort_busy",     {31'd0, busy}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      push_frame(3, NP);
      wait_frame("frame_after_abort_done");

      set_frame(4); push_frame(4, NP); wait_frame("frame_clamp_done");

      repeat (20) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
